// File: rtl/ysyx_25030093_idu.sv
// Instruction decode unit: single-entry pipeline register between IFU and EXU.
// Decodes RV32E instructions into class, register fields, funct bits and immediate.
module ysyx_25030093_idu #(
    parameter int NREG = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  opclass,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic        f7b5,
    output logic [31:0] imm,
    output logic        illegal
);

    localparam logic [3:0] C_LUI = 4'd0, C_AUIPC = 4'd1, C_JAL = 4'd2, C_JALR = 4'd3,
                           C_BRANCH = 4'd4, C_LOAD = 4'd5, C_STORE = 4'd6, C_OPIMM = 4'd7,
                           C_OP = 4'd8, C_SYSTEM = 4'd9, C_ILL = 4'd15;

    function automatic logic idx_bad(input logic [4:0] idx);
        return int'(idx) >= NREG;
    endfunction

    logic        full_q, full_d;
    logic [31:0] pc_q, imm_q;
    logic [3:0]  cls_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [2:0]  f3_q;
    logic        f7b5_q, ill_q;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]  dec_cls;
    logic [31:0] dec_imm;
    logic        use_rd, use_rs1, use_rs2, dec_f7b5, dec_bad;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        accept;

    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        dec_cls  = C_ILL;
        dec_imm  = 32'd0;
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        dec_f7b5 = 1'b0;
        dec_bad  = 1'b0;
        // Opcode includes inst[1:0], so non-32-bit encodings fall to default.
        case (inst[6:0])
            7'b0110111: begin dec_cls = C_LUI;   use_rd = 1'b1; dec_imm = imm_u; end
            7'b0010111: begin dec_cls = C_AUIPC; use_rd = 1'b1; dec_imm = imm_u; end
            7'b1101111: begin dec_cls = C_JAL;   use_rd = 1'b1; dec_imm = imm_j; end
            7'b1100111: begin dec_cls = C_JALR;  use_rd = 1'b1; use_rs1 = 1'b1; dec_imm = imm_i; end
            7'b1100011: begin
                dec_cls = C_BRANCH; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm = imm_b;
                dec_bad = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'b0000011: begin
                dec_cls = C_LOAD; use_rd = 1'b1; use_rs1 = 1'b1; dec_imm = imm_i;
                dec_bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            7'b0100011: begin
                dec_cls = C_STORE; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_imm = imm_s;
                dec_bad = (f3 > 3'd2);
            end
            7'b0010011: begin
                dec_cls = C_OPIMM; use_rd = 1'b1; use_rs1 = 1'b1; dec_imm = imm_i;
                dec_f7b5 = (f3 == 3'd1 || f3 == 3'd5) ? inst[30] : 1'b0;
            end
            7'b0110011: begin
                dec_cls = C_OP; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_f7b5 = inst[30];
                dec_bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'b1110011: begin dec_cls = C_SYSTEM; use_rd = 1'b1; use_rs1 = 1'b1; end
            default:    dec_bad = 1'b1;
        endcase
        dec_rd  = use_rd  ? inst[11:7]  : 5'd0;
        dec_rs1 = use_rs1 ? inst[19:15] : 5'd0;
        dec_rs2 = use_rs2 ? inst[24:20] : 5'd0;
        if ((use_rd && idx_bad(dec_rd)) || (use_rs1 && idx_bad(dec_rs1)) ||
            (use_rs2 && idx_bad(dec_rs2)))
            dec_bad = 1'b1;
        if (dec_bad)
            dec_cls = C_ILL;
    end

    assign in_ready = !full_q || out_ready || flush;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        full_d = full_q;
        if (flush)
            full_d = 1'b0;
        else if (accept)
            full_d = 1'b1;
        else if (full_q && out_ready)
            full_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            pc_q   <= 32'd0;
            imm_q  <= 32'd0;
            cls_q  <= 4'd0;
            rd_q   <= 5'd0;
            rs1_q  <= 5'd0;
            rs2_q  <= 5'd0;
            f3_q   <= 3'd0;
            f7b5_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            if (accept) begin
                pc_q   <= pc;
                imm_q  <= dec_imm;
                cls_q  <= dec_cls;
                rd_q   <= dec_rd;
                rs1_q  <= dec_rs1;
                rs2_q  <= dec_rs2;
                f3_q   <= f3;
                f7b5_q <= dec_f7b5;
                ill_q  <= dec_bad;
            end
        end
    end

    assign out_valid = full_q;
    assign out_pc    = pc_q;
    assign opclass   = cls_q;
    assign rd        = rd_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign funct3    = f3_q;
    assign f7b5      = f7b5_q;
    assign imm       = imm_q;
    assign illegal   = ill_q;

endmodule
